exit_queue_txbuf: RTL and testbench

// - Per-port egress exit queue between the crossbar output and one line card TX port (fabric clock domain).
// - Store-and-forward: a frame becomes visible on TX only once its tlast beat is written.
// - Crossbar input is never backpressured; a frame that overflows the buffer is dropped whole.
// - Transmit side is a standard AXI-stream sender that tolerates arbitrary tx_tready stalls.

---
 rtl/exit_queue_txbuf.sv | 239 +++++++++++++++++++++++
 tb/tb_exit_queue_txbuf.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exit_queue_txbuf.sv
// ---------------------------------------------------------------------------
// exit_queue_txbuf
//
// Per-port egress exit queue sitting between the crossbar output and one
// line-card TX port. Everything runs in the fabric clock domain.
//
// Store-and-forward: a frame only becomes visible on TX once its tlast beat
// has been written. The crossbar side is never backpressured; a frame that
// does not fit in the buffer is dropped whole and counted. The TX side is a
// plain AXI-stream sender that tolerates arbitrary tx_tready stalls.
//
// Optional feature macro: EXIT_QUEUE_STATS_EN
//   defined   -> adds saturating frames_sent[31:0] and bytes_sent[47:0]
//   undefined -> those ports and their logic do not exist
//
// Ports
//   clk_fabric      fabric clock
//   rst_n           synchronous active-low reset
//   xbar_t*         crossbar AXI-stream input (xbar_tready tied high)
//   tx_t*           TX AXI-stream output
//   frames_dropped  saturating count of dropped frames
//   frames_sent     (stats build) saturating count of sent frames
//   bytes_sent      (stats build) saturating count of sent bytes
// ---------------------------------------------------------------------------
module exit_queue_txbuf #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 12,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk_fabric,
    input  logic                    rst_n,
    input  logic                    xbar_tvalid,
    output logic                    xbar_tready,
    input  logic [DATA_WIDTH-1:0]   xbar_tdata,
    input  logic [DATA_WIDTH/8-1:0] xbar_tkeep,
    input  logic [USER_WIDTH-1:0]   xbar_tuser,
    input  logic                    xbar_tlast,
    output logic                    tx_tvalid,
    input  logic                    tx_tready,
    output logic [DATA_WIDTH-1:0]   tx_tdata,
    output logic [DATA_WIDTH/8-1:0] tx_tkeep,
    output logic [USER_WIDTH-1:0]   tx_tuser,
    output logic                    tx_tlast,
    output logic [31:0]             frames_dropped
`ifdef EXIT_QUEUE_STATS_EN
    ,
    output logic [31:0]             frames_sent,
    output logic [47:0]             bytes_sent
`endif
);

    localparam int ADDR_BITS  = $clog2(DEPTH);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int WORD_WIDTH = 1 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

    typedef logic [ADDR_BITS:0] ptr_t;
    localparam ptr_t PTR_ONE    = ptr_t'(1);
    localparam ptr_t FULL_LEVEL = ptr_t'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP
    } wr_state_t;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    wr_state_t             state_q, state_d;
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  commit_ptr_q, commit_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  frame_start_q, frame_start_d;
    logic [USER_WIDTH-1:0] frame_user_q, frame_user_d;
    logic [31:0]           frames_dropped_q, frames_dropped_d;
    logic                  tx_tvalid_q, tx_tvalid_d;
    logic [WORD_WIDTH-1:0] tx_word_q;

    logic                  full;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  rd_en;

    assign xbar_tready = 1'b1;

    // Occupancy is measured against the read pointer as it stands before
    // this cycle's read, so a same-cycle pop never makes room early.
    assign full = (wr_ptr_q - rd_ptr_q) == FULL_LEVEL;

    // ---------------- write side ----------------
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        commit_ptr_d     = commit_ptr_q;
        frame_start_d    = frame_start_q;
        frame_user_d     = frame_user_q;
        frames_dropped_d = frames_dropped_q;
        mem_we           = 1'b0;
        mem_wdata        = {xbar_tlast, frame_user_q, xbar_tkeep, xbar_tdata};

        unique case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (xbar_tvalid) begin
                    // First beat of a frame: remember where it started and its
                    // VLAN; the beat itself is then handled like any other.
                    if (state_q == ST_IDLE) begin
                        frame_start_d = wr_ptr_q;
                        frame_user_d  = xbar_tuser;
                        mem_wdata     = {xbar_tlast, xbar_tuser, xbar_tkeep, xbar_tdata};
                    end
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (xbar_tlast) begin
                            commit_ptr_d = wr_ptr_q + PTR_ONE;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        // Rewind over the partial frame and discard the rest.
                        wr_ptr_d = (state_q == ST_IDLE) ? wr_ptr_q : frame_start_q;
                        if (frames_dropped_q != 32'hFFFF_FFFF) begin
                            frames_dropped_d = frames_dropped_q + 32'd1;
                        end
                        state_d = xbar_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (xbar_tvalid && xbar_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_fabric) begin
        if (mem_we) begin
            mem[wr_ptr_q[ADDR_BITS-1:0]] <= mem_wdata;
        end
    end

    // ---------------- read side ----------------
    // The TX output register doubles as the RAM read register: a word is
    // fetched whenever committed data exists and the register is empty or
    // being drained this cycle, giving one beat per clock when unstalled.
    always_comb begin
        rd_en       = (rd_ptr_q != commit_ptr_q) && (!tx_tvalid_q || tx_tready);
        rd_ptr_d    = rd_ptr_q;
        tx_tvalid_d = tx_tvalid_q;
        if (rd_en) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            tx_tvalid_d = 1'b1;
        end else if (tx_tready) begin
            tx_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_fabric) begin
        if (!rst_n) begin
            tx_word_q <= '0;
        end else if (rd_en) begin
            tx_word_q <= mem[rd_ptr_q[ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clk_fabric) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            commit_ptr_q     <= '0;
            rd_ptr_q         <= '0;
            frame_start_q    <= '0;
            frame_user_q     <= '0;
            frames_dropped_q <= '0;
            tx_tvalid_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            commit_ptr_q     <= commit_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            frame_start_q    <= frame_start_d;
            frame_user_q     <= frame_user_d;
            frames_dropped_q <= frames_dropped_d;
            tx_tvalid_q      <= tx_tvalid_d;
        end
    end

    assign tx_tvalid      = tx_tvalid_q;
    assign {tx_tlast, tx_tuser, tx_tkeep, tx_tdata} = tx_word_q;
    assign frames_dropped = frames_dropped_q;

`ifdef EXIT_QUEUE_STATS_EN
    // ---------------- TX statistics ----------------
    localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

    logic [CNT_W-1:0] keep_ones;
    logic [48:0]      bytes_sum;
    logic [31:0]      frames_sent_q, frames_sent_d;
    logic [47:0]      bytes_sent_q, bytes_sent_d;
    logic             tx_fire;

    assign tx_fire = tx_tvalid_q & tx_tready;

    always_comb begin
        keep_ones = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_ones = keep_ones + CNT_W'(tx_tkeep[i]);
        end
        // One spare bit catches the carry so the counter can saturate.
        bytes_sum     = {1'b0, bytes_sent_q} + 49'(keep_ones);
        frames_sent_d = frames_sent_q;
        bytes_sent_d  = bytes_sent_q;
        if (tx_fire) begin
            bytes_sent_d = bytes_sum[48] ? 48'hFFFF_FFFF_FFFF : bytes_sum[47:0];
            if (tx_tlast && frames_sent_q != 32'hFFFF_FFFF) begin
                frames_sent_d = frames_sent_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_fabric) begin
        if (!rst_n) begin
            frames_sent_q <= '0;
            bytes_sent_q  <= '0;
        end else begin
            frames_sent_q <= frames_sent_d;
            bytes_sent_q  <= bytes_sent_d;
        end
    end

    assign frames_sent = frames_sent_q;
    assign bytes_sent  = bytes_sent_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_exit_queue_txbuf.sv
// ---------------------------------------------------------------------------
// tb_exit_queue_txbuf
//
// Directed testbench for exit_queue_txbuf built with DEPTH=16. A negedge
// monitor records every accepted TX beat and watches for outputs changing
// while stalled; each test task drives its scenario and checks the result.
// Stats checks are compiled only when EXIT_QUEUE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_exit_queue_txbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        xbar_tvalid;
    logic        xbar_tready;
    logic [63:0] xbar_tdata;
    logic [7:0]  xbar_tkeep;
    logic [11:0] xbar_tuser;
    logic        xbar_tlast;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic [11:0] tx_tuser;
    logic        tx_tlast;
    logic [31:0] frames_dropped;
`ifdef EXIT_QUEUE_STATS_EN
    logic [31:0] frames_sent;
    logic [47:0] bytes_sent;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0] rx_data [$];
    logic [7:0]  rx_keep [$];
    logic [11:0] rx_user [$];
    logic        rx_last [$];

    logic        mon_stalled = 1'b0;
    logic [63:0] stall_data;
    logic [7:0]  stall_keep;
    logic [11:0] stall_user;
    logic        stall_last;
    int          stall_viol = 0;
    int          stall_events = 0;

    always #5 clk = ~clk;

    exit_queue_txbuf #(
        .DATA_WIDTH(64),
        .USER_WIDTH(12),
        .DEPTH     (16)
    ) dut (
        .clk_fabric    (clk),
        .rst_n         (rst_n),
        .xbar_tvalid   (xbar_tvalid),
        .xbar_tready   (xbar_tready),
        .xbar_tdata    (xbar_tdata),
        .xbar_tkeep    (xbar_tkeep),
        .xbar_tuser    (xbar_tuser),
        .xbar_tlast    (xbar_tlast),
        .tx_tvalid     (tx_tvalid),
        .tx_tready     (tx_tready),
        .tx_tdata      (tx_tdata),
        .tx_tkeep      (tx_tkeep),
        .tx_tuser      (tx_tuser),
        .tx_tlast      (tx_tlast),
        .frames_dropped(frames_dropped)
`ifdef EXIT_QUEUE_STATS_EN
        ,
        .frames_sent   (frames_sent),
        .bytes_sent    (bytes_sent)
`endif
    );

    // Inputs change just after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (rst_n && tx_tvalid && tx_tready) begin
            rx_data.push_back(tx_tdata);
            rx_keep.push_back(tx_tkeep);
            rx_user.push_back(tx_tuser);
            rx_last.push_back(tx_tlast);
        end
        if (mon_stalled && rst_n) begin
            if (!tx_tvalid || tx_tdata !== stall_data || tx_tkeep !== stall_keep ||
                tx_tuser !== stall_user || tx_tlast !== stall_last) begin
                stall_viol <= stall_viol + 1;
            end
        end
        if (rst_n && tx_tvalid && !tx_tready) begin
            stall_events <= stall_events + 1;
        end
        mon_stalled <= rst_n && tx_tvalid && !tx_tready;
        stall_data  <= tx_tdata;
        stall_keep  <= tx_tkeep;
        stall_user  <= tx_tuser;
        stall_last  <= tx_tlast;
    end

    function automatic logic [63:0] beat_data(input logic [7:0] fid, input int idx);
        return {24'hC0FFEE, fid, 32'(idx)};
    endfunction

    task automatic clear_rx();
        rx_data.delete();
        rx_keep.delete();
        rx_user.delete();
        rx_last.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_input();
        xbar_tvalid = 1'b0;
        xbar_tdata  = '0;
        xbar_tkeep  = '0;
        xbar_tuser  = '0;
        xbar_tlast  = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic [11:0] u, input logic l);
        xbar_tvalid = 1'b1;
        xbar_tdata  = d;
        xbar_tkeep  = k;
        xbar_tuser  = u;
        xbar_tlast  = l;
        cycles(1);
    endtask

    task automatic send_frame(input logic [7:0] fid, input int n,
                              input logic [11:0] u, input logic [7:0] last_keep);
        for (int i = 0; i < n; i++) begin
            drive_beat(beat_data(fid, i), (i == n - 1) ? last_keep : 8'hFF, u, i == n - 1);
        end
        idle_input();
    endtask

    task automatic apply_reset();
        idle_input();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        idle_input();
        tx_tready = 1'b1;
        rst_n = 1'b0;
        cycles(3);
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", tx_tvalid); end
        checks++; if (tx_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", tx_tdata); end
        checks++; if (tx_tkeep !== 8'h0) begin errors++; $display("FAIL reset_tkeep: got %h want 0", tx_tkeep); end
        checks++; if (tx_tuser !== 12'h0) begin errors++; $display("FAIL reset_tuser: got %h want 0", tx_tuser); end
        checks++; if (tx_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", tx_tlast); end
        checks++; if (frames_dropped !== 32'd0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", frames_dropped); end
        checks++; if (xbar_tready !== 1'b1) begin errors++; $display("FAIL xbar_tready: got %b want 1", xbar_tready); end
        rst_n = 1'b1;
        cycles(1);
        $display("test_reset done");
    endtask

    task automatic test_basic_frame();
        logic [7:0]  exp_keep [3];
        exp_keep[0] = 8'hFF; exp_keep[1] = 8'hFF; exp_keep[2] = 8'h0F;
        clear_rx();
        tx_tready = 1'b1;
        // Later beats carry a different tuser; the first beat's VLAN must win.
        drive_beat(beat_data(8'h10, 0), 8'hFF, 12'h00A, 1'b0);
        drive_beat(beat_data(8'h10, 1), 8'hFF, 12'hFFF, 1'b0);
        drive_beat(beat_data(8'h10, 2), 8'h0F, 12'hFFF, 1'b1);
        idle_input();
        checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL latency_n1: tvalid got %b want 0", tx_tvalid); end
        cycles(1);
        checks++; if (tx_tvalid !== 1'b1) begin errors++; $display("FAIL latency_n2: tvalid got %b want 1", tx_tvalid); end
        checks++; if (tx_tdata !== beat_data(8'h10, 0)) begin errors++; $display("FAIL latency_data: got %h want %h", tx_tdata, beat_data(8'h10, 0)); end
        cycles(10);
        checks++; if (rx_data.size() != 3) begin errors++; $display("FAIL basic_count: got %0d want 3", rx_data.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_data.size()) begin
                checks++; if (rx_data[i] !== beat_data(8'h10, i)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, rx_data[i], beat_data(8'h10, i)); end
                checks++; if (rx_keep[i] !== exp_keep[i]) begin errors++; $display("FAIL basic_keep[%0d]: got %h want %h", i, rx_keep[i], exp_keep[i]); end
                checks++; if (rx_user[i] !== 12'h00A) begin errors++; $display("FAIL basic_user[%0d]: got %h want 00a", i, rx_user[i]); end
                checks++; if (rx_last[i] !== (i == 2)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", i, rx_last[i], i == 2); end
            end
        end
        checks++; if (frames_dropped !== 32'd0) begin errors++; $display("FAIL basic_dropped: got %0d want 0", frames_dropped); end
        $display("test_basic_frame done: %0d beats", rx_data.size());
    endtask

    task automatic test_zero_keep();
        clear_rx();
        tx_tready = 1'b1;
        drive_beat(beat_data(8'h11, 0), 8'h00, 12'h321, 1'b1);
        idle_input();
        cycles(6);
        checks++; if (rx_data.size() != 1) begin errors++; $display("FAIL zkeep_count: got %0d want 1", rx_data.size()); end
        if (rx_data.size() > 0) begin
            checks++; if (rx_data[0] !== beat_data(8'h11, 0) || rx_keep[0] !== 8'h00 || rx_user[0] !== 12'h321 || rx_last[0] !== 1'b1) begin
                errors++; $display("FAIL zkeep_beat: got %h/%h/%h/%b want %h/00/321/1", rx_data[0], rx_keep[0], rx_user[0], rx_last[0], beat_data(8'h11, 0));
            end
        end
        $display("test_zero_keep done: %0d beats", rx_data.size());
    endtask

    task automatic test_oversize_drop();
        clear_rx();
        tx_tready = 1'b1;
        send_frame(8'h20, 20, 12'h020, 8'hFF);
        send_frame(8'h21, 4, 12'h021, 8'h3F);
        cycles(12);
        checks++; if (frames_dropped !== 32'd1) begin errors++; $display("FAIL oversize_dropped: got %0d want 1", frames_dropped); end
        checks++; if (rx_data.size() != 4) begin errors++; $display("FAIL oversize_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rx_data.size()) begin
                checks++; if (rx_data[i] !== beat_data(8'h21, i) || rx_user[i] !== 12'h021 || rx_last[i] !== (i == 3)) begin
                    errors++; $display("FAIL oversize_beat[%0d]: got %h/%h/%b want %h/021/%b", i, rx_data[i], rx_user[i], rx_last[i], beat_data(8'h21, i), i == 3);
                end
            end
        end
        checks++; if (rx_keep.size() == 4 && rx_keep[3] !== 8'h3F) begin errors++; $display("FAIL oversize_keep: got %h want 3f", rx_keep[3]); end
        $display("test_oversize_drop done: %0d beats", rx_data.size());
    endtask

    task automatic test_back_to_back();
        clear_rx();
        stall_viol = 0;
        stall_events = 0;
        tx_tready = 1'b1;
        fork
            begin
                send_frame(8'h30, 8, 12'h130, 8'hFF);
                send_frame(8'h31, 8, 12'h131, 8'hFF);
            end
            begin
                for (int c = 0; c < 50; c++) begin
                    tx_tready = ~tx_tready;
                    cycles(1);
                end
                tx_tready = 1'b1;
            end
        join
        cycles(10);
        checks++; if (rx_data.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", rx_data.size()); end
        for (int j = 0; j < 16; j++) begin
            if (j < rx_data.size()) begin
                checks++; if (rx_data[j] !== beat_data((j < 8) ? 8'h30 : 8'h31, j % 8) || rx_last[j] !== (j % 8 == 7) ||
                              rx_user[j] !== ((j < 8) ? 12'h130 : 12'h131)) begin
                    errors++; $display("FAIL b2b_beat[%0d]: got %h/%h/%b want %h/%h/%b", j, rx_data[j], rx_user[j], rx_last[j],
                                       beat_data((j < 8) ? 8'h30 : 8'h31, j % 8), (j < 8) ? 12'h130 : 12'h131, j % 8 == 7);
                end
            end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL b2b_stable: got %0d changes while stalled want 0", stall_viol); end
        checks++; if (stall_events == 0) begin errors++; $display("FAIL b2b_stalls: got 0 stalled cycles want >0"); end
        $display("test_back_to_back done: %0d beats, %0d stalled cycles", rx_data.size(), stall_events);
    endtask

    task automatic test_full_drop();
        apply_reset();
        clear_rx();
        tx_tready = 1'b0;
        send_frame(8'h40, 4, 12'h040, 8'hFF);
        send_frame(8'h41, 4, 12'h041, 8'hFF);
        send_frame(8'h42, 4, 12'h042, 8'hFF);
        send_frame(8'h43, 6, 12'h043, 8'hFF);
        cycles(2);
        checks++; if (frames_dropped !== 32'd1) begin errors++; $display("FAIL full_dropped: got %0d want 1", frames_dropped); end
        checks++; if (dut.wr_ptr_q !== 5'd12) begin errors++; $display("FAIL full_wr_ptr: got %0d want 12", dut.wr_ptr_q); end
        checks++; if (rx_data.size() != 0) begin errors++; $display("FAIL full_stalled: got %0d beats want 0", rx_data.size()); end
        tx_tready = 1'b1;
        cycles(20);
        checks++; if (rx_data.size() != 12) begin errors++; $display("FAIL full_count: got %0d want 12", rx_data.size()); end
        for (int j = 0; j < 12; j++) begin
            if (j < rx_data.size()) begin
                checks++; if (rx_data[j] !== beat_data(8'(8'h40 + j / 4), j % 4) || rx_last[j] !== (j % 4 == 3)) begin
                    errors++; $display("FAIL full_beat[%0d]: got %h/%b want %h/%b", j, rx_data[j], rx_last[j], beat_data(8'(8'h40 + j / 4), j % 4), j % 4 == 3);
                end
            end
        end
        $display("test_full_drop done: %0d beats", rx_data.size());
    endtask

    task automatic test_reset_midframe();
        clear_rx();
        tx_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(beat_data(8'h50, i), 8'hFF, 12'h050, 1'b0);
        end
        idle_input();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        send_frame(8'h51, 2, 12'h051, 8'h07);
        cycles(8);
        checks++; if (rx_data.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", rx_data.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < rx_data.size()) begin
                checks++; if (rx_data[i] !== beat_data(8'h51, i) || rx_user[i] !== 12'h051 || rx_last[i] !== (i == 1)) begin
                    errors++; $display("FAIL midrst_beat[%0d]: got %h/%h/%b want %h/051/%b", i, rx_data[i], rx_user[i], rx_last[i], beat_data(8'h51, i), i == 1);
                end
            end
        end
        checks++; if (frames_dropped !== 32'd0) begin errors++; $display("FAIL midrst_dropped: got %0d want 0", frames_dropped); end
        $display("test_reset_midframe done: %0d beats", rx_data.size());
    endtask

`ifdef EXIT_QUEUE_STATS_EN
    task automatic test_stats();
        apply_reset();
        clear_rx();
        tx_tready = 1'b1;
        checks++; if (frames_sent !== 32'd0 || bytes_sent !== 48'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d want 0/0", frames_sent, bytes_sent); end
        send_frame(8'h60, 8, 12'h060, 8'hFF);
        send_frame(8'h61, 9, 12'h061, 8'h01);
        cycles(30);
        checks++; if (frames_sent !== 32'd2) begin errors++; $display("FAIL stats_frames: got %0d want 2", frames_sent); end
        checks++; if (bytes_sent !== 48'd129) begin errors++; $display("FAIL stats_bytes: got %0d want 129", bytes_sent); end
        $display("test_stats done: frames=%0d bytes=%0d", frames_sent, bytes_sent);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        tx_tready = 1'b1;
        idle_input();
        @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_zero_keep();
        test_oversize_drop();
        test_back_to_back();
        test_full_drop();
        test_reset_midframe();
`ifdef EXIT_QUEUE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
